// File: rtl/main_fsm_if.sv
// main_fsm_pkg / main_fsm_if
// Shared encodings for the multi-cycle RV32I control unit, and the bundle of
// control/handshake signals between the FSM (master) and the datapath (slave).
// Optional feature macro used by main_fsm: FSM_ILLEGAL_TRAP_EN.

package main_fsm_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_LT   = 4'd3,
    ALU_LTU  = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_EQ   = 4'd10,
    ALU_NEQ  = 4'd11,
    ALU_GTE  = 4'd12,
    ALU_GTEU = 4'd13
  } alu_op_e;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEM_ADR = 4'd2,
    S_MEM_RD  = 4'd3,
    S_WB_MEM  = 4'd4,
    S_MEM_WR  = 4'd5,
    S_EXEC_R  = 4'd6,
    S_EXEC_I  = 4'd7,
    S_WB_ALU  = 4'd8,
    S_BRANCH  = 4'd9,
    S_LINK    = 4'd10,
    S_JUMP    = 4'd11,
    S_LUI     = 4'd12,
    S_TRAP    = 4'd13
  } state_e;

  typedef enum logic [1:0] {
    SRC_A_PC     = 2'd0,
    SRC_A_OLD_PC = 2'd1,
    SRC_A_RS1    = 2'd2,
    SRC_A_ZERO   = 2'd3
  } src_a_e;

  typedef enum logic [1:0] {
    SRC_B_RS2  = 2'd0,
    SRC_B_IMM  = 2'd1,
    SRC_B_FOUR = 2'd2
  } src_b_e;

  typedef enum logic [1:0] {
    RES_ALU_OUT = 2'd0,
    RES_MDR     = 2'd1,
    RES_ALU     = 2'd2,
    RES_PC      = 2'd3
  } result_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

endpackage

interface main_fsm_if;
  logic [31:0] instr_i;
  logic        alu_zero_flag_i;
  logic        mem_ready_i;
  logic        mem_req_o;
  logic        mem_write_o;
  logic        adr_sel_o;
  logic        ir_write_o;
  logic        pc_write_o;
  logic        reg_write_o;
  logic [1:0]  alu_src_a_sel_o;
  logic [1:0]  alu_src_b_sel_o;
  logic [3:0]  alu_control_o;
  logic [1:0]  result_sel_o;
  logic        illegal_instr_o;
  logic [3:0]  state_o;

  modport master (
    input  instr_i, alu_zero_flag_i, mem_ready_i,
    output mem_req_o, mem_write_o, adr_sel_o, ir_write_o, pc_write_o,
           reg_write_o, alu_src_a_sel_o, alu_src_b_sel_o, alu_control_o,
           result_sel_o, illegal_instr_o, state_o
  );

  modport slave (
    output instr_i, alu_zero_flag_i, mem_ready_i,
    input  mem_req_o, mem_write_o, adr_sel_o, ir_write_o, pc_write_o,
           reg_write_o, alu_src_a_sel_o, alu_src_b_sel_o, alu_control_o,
           result_sel_o, illegal_instr_o, state_o
  );
endinterface

// File: rtl/main_fsm.sv
// main_fsm
// Multi-cycle RV32I main control unit: fetch, decode, execute, memory and
// writeback sequencing for a shared-ALU datapath. All outputs are decoded
// combinationally from the current state (plus handshake/instruction inputs).
// Optional: define FSM_ILLEGAL_TRAP_EN to make illegal encodings enter a
// terminal TRAP state with a sticky illegal_instr_o; otherwise they retire
// as a NOP and illegal_instr_o is tied 0.

module main_fsm
  import main_fsm_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  main_fsm_if.master    bus
);

`ifdef FSM_ILLEGAL_TRAP_EN
  localparam state_e ILLEGAL_DEST = S_TRAP;
`else
  localparam state_e ILLEGAL_DEST = S_FETCH;
`endif

  state_e     state_q, state_d;
  logic       mem_req, mem_write, adr_sel, ir_write, pc_write, reg_write;
  src_a_e     src_a;
  src_b_e     src_b;
  alu_op_e    alu_op;
  result_e    result_sel;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       unused_instr_bits;

  assign opcode   = bus.instr_i[6:0];
  assign funct3   = bus.instr_i[14:12];
  assign funct7_5 = bus.instr_i[30];
  assign unused_instr_bits = ^{bus.instr_i[31], bus.instr_i[29:15], bus.instr_i[11:7]};

  // Shared R/I-type operation table; alt selects SUB/SRA.
  function automatic alu_op_e arith_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  arith_op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  arith_op = ALU_SLL;
      3'b010:  arith_op = ALU_LT;
      3'b011:  arith_op = ALU_LTU;
      3'b100:  arith_op = ALU_XOR;
      3'b101:  arith_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  arith_op = ALU_OR;
      default: arith_op = ALU_AND;
    endcase
  endfunction

  function automatic alu_op_e branch_op(input logic [2:0] f3);
    case (f3)
      3'b001:  branch_op = ALU_NEQ;
      3'b100:  branch_op = ALU_LT;
      3'b101:  branch_op = ALU_GTE;
      3'b110:  branch_op = ALU_LTU;
      3'b111:  branch_op = ALU_GTEU;
      default: branch_op = ALU_EQ;
    endcase
  endfunction

  // State register; reset returns to FETCH asynchronously.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples pre-edge values regardless of block ordering.
    if (rst_i) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state and control decode.
  always_comb begin
    // NOTE: every output gets a default before the case, so no path can
    // leave a signal unassigned and infer a latch.
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_sel    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    src_a      = SRC_A_PC;
    src_b      = SRC_B_RS2;
    alu_op     = ALU_ADD;
    result_sel = RES_ALU_OUT;

    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (bus.mem_ready_i) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          src_b      = SRC_B_FOUR;
          result_sel = RES_ALU;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        // Precompute branch/JAL target into alu_out while dispatching.
        src_a = SRC_A_OLD_PC;
        src_b = SRC_B_IMM;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEM_ADR;
          OP_REG:            state_d = S_EXEC_R;
          OP_IMM:            state_d = S_EXEC_I;
          OP_BRANCH:         state_d = (funct3[2:1] == 2'b01) ? ILLEGAL_DEST : S_BRANCH;
          OP_JAL, OP_JALR:   state_d = S_LINK;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_WB_ALU;
          default:           state_d = ILLEGAL_DEST;
        endcase
      end
      S_EXEC_R: begin
        src_a   = SRC_A_RS1;
        alu_op  = arith_op(funct3, funct7_5);
        state_d = S_WB_ALU;
      end
      S_EXEC_I: begin
        src_a   = SRC_A_RS1;
        src_b   = SRC_B_IMM;
        alu_op  = arith_op(funct3, funct7_5 && (funct3 == 3'b101));
        state_d = S_WB_ALU;
      end
      S_LUI: begin
        src_a   = SRC_A_ZERO;
        src_b   = SRC_B_IMM;
        state_d = S_WB_ALU;
      end
      S_WB_ALU: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEM_ADR: begin
        src_a   = SRC_A_RS1;
        src_b   = SRC_B_IMM;
        state_d = opcode[5] ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        adr_sel = 1'b1;
        if (bus.mem_ready_i) state_d = S_WB_MEM;
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        result_sel = RES_MDR;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_sel   = 1'b1;
        if (bus.mem_ready_i) state_d = S_FETCH;
      end
      S_BRANCH: begin
        src_a    = SRC_A_RS1;
        alu_op   = branch_op(funct3);
        pc_write = bus.alu_zero_flag_i;
        state_d  = S_FETCH;
      end
      S_LINK: begin
        reg_write  = 1'b1;
        result_sel = RES_PC;
        src_a      = opcode[3] ? SRC_A_OLD_PC : SRC_A_RS1;
        src_b      = SRC_B_IMM;
        state_d    = S_JUMP;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        state_d  = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  // Strobes are masked by reset so an in-flight access is dropped at once.
  assign bus.mem_req_o       = mem_req   & ~rst_i;
  assign bus.mem_write_o     = mem_write & ~rst_i;
  assign bus.ir_write_o      = ir_write  & ~rst_i;
  assign bus.pc_write_o      = pc_write  & ~rst_i;
  assign bus.reg_write_o     = reg_write & ~rst_i;
  assign bus.adr_sel_o       = adr_sel;
  assign bus.alu_src_a_sel_o = src_a;
  assign bus.alu_src_b_sel_o = src_b;
  assign bus.alu_control_o   = alu_op;
  assign bus.result_sel_o    = result_sel;
  assign bus.state_o         = state_q;

`ifdef FSM_ILLEGAL_TRAP_EN
  // TRAP is terminal until reset, so being in it is the sticky flag.
  assign bus.illegal_instr_o = (state_q == S_TRAP);
`else
  assign bus.illegal_instr_o = 1'b0;
`endif

endmodule
